// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared states, counter widths and check-edge helper for the UART receiver
package uart_rx_pkg;
  localparam int EDGE_W = 5;
  localparam int BIT_W = 4;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic logic [5:0] pre_chk(input logic [5:0] ps);
    return {1'b0, ps[5:1]} + 6'd1;
  endfunction
endpackage

// File: rtl/uart_edge_bit_counter.sv
// uart_edge_bit_counter: oversample edge and data-bit position counters
import uart_rx_pkg::*;
module uart_edge_bit_counter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              bit_en,
  input  logic [5:0]        prescale,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              bit_end,
  output logic              last_bit
);
  assign bit_end = {1'b0, edge_cnt} == prescale - 6'd1;
  assign last_bit = bit_cnt == BIT_W'(DATA_WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      edge_cnt <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      edge_cnt <= bit_end ? '0 : edge_cnt + 1'b1;
      bit_cnt <= (bit_en && bit_end) ? (last_bit ? '0 : bit_cnt + 1'b1) : bit_cnt;
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer driving datapath strobes and result pulses
import uart_rx_pkg::*;
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic [5:0]        prescale,
  input  logic              strt_glitch,
  input  logic              par_err,
  input  logic              stp_err,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              dat_samp_en,
  output logic              strt_chk_en,
  output logic              deser_en,
  output logic              par_chk_en,
  output logic              stp_chk_en,
  output logic              data_valid,
  output logic              parity_error,
  output logic              framing_error
);
  state_t state, next_state;
  logic [5:0] ps_q;
  logic par_q, par_flag, bit_end, last_bit, pre, start;
  assign pre = {1'b0, edge_cnt} == pre_chk(ps_q);
  assign start = next_state == START && state != START;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = RX_IN ? IDLE : START;
      START:   next_state = (strt_chk_en && strt_glitch) ? IDLE : bit_end ? DATA : START;
      DATA:    next_state = (bit_end && last_bit) ? (par_q ? PARITY : STOP) : DATA;
      PARITY:  next_state = bit_end ? STOP : PARITY;
      STOP:    next_state = bit_end ? (RX_IN ? IDLE : START) : STOP;
      default: next_state = IDLE;
    endcase
  end
  uart_edge_bit_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cnt (
    .clk(CLK),
    .rst(RST),
    .en(state != IDLE),
    .clr(next_state == IDLE),
    .bit_en(state == DATA),
    .prescale(ps_q),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .bit_end(bit_end),
    .last_bit(last_bit)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ps_q <= '0;
      par_q <= 1'b0;
      par_flag <= 1'b0;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en <= 1'b0;
      par_chk_en <= 1'b0;
      stp_chk_en <= 1'b0;
      data_valid <= 1'b0;
      parity_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state <= next_state;
      ps_q <= start ? prescale : ps_q;
      par_q <= start ? PAR_EN : par_q;
      par_flag <= (state == STOP && bit_end) ? 1'b0 : par_flag | (par_chk_en & par_err);
      dat_samp_en <= next_state != IDLE;
      strt_chk_en <= pre && state == START;
      deser_en <= pre && state == DATA;
      par_chk_en <= pre && state == PARITY;
      stp_chk_en <= pre && state == STOP;
      data_valid <= stp_chk_en && !stp_err && !par_flag;
      framing_error <= stp_chk_en && stp_err;
      parity_error <= stp_chk_en && !stp_err && par_flag;
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with hand-computed strobe/pulse cycles
module tb_uart_rx_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic RX_IN = 1'b1;
  logic PAR_EN = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic strt_glitch = 1'b0;
  logic par_err = 1'b0;
  logic stp_err = 1'b0;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
  logic data_valid, parity_error, framing_error;
  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  logic [6:0] mon_v;
  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;
  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .PAR_EN(PAR_EN),
    .prescale(prescale),
    .strt_glitch(strt_glitch),
    .par_err(par_err),
    .stp_err(stp_err),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en),
    .deser_en(deser_en),
    .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en),
    .data_valid(data_valid),
    .parity_error(parity_error),
    .framing_error(framing_error)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic string kname(input int k);
    case (k)
      0: return "strt_chk_en";
      1: return "deser_en";
      2: return "par_chk_en";
      3: return "stp_chk_en";
      4: return "data_valid";
      5: return "parity_error";
      6: return "framing_error";
      default: return "none";
    endcase
  endfunction
  always @(negedge CLK) begin
    mon_v = {framing_error, parity_error, data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en};
    for (int k = 0; k < 7; k++) begin
      if (mon_v[k] === 1'b1) begin
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ev_unexpected: got %s @%0d, expected nothing", kname(k), cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind != k || mon_e.at != cyc) begin
            n_fail++;
            $display("FAIL ev_order: got %s @%0d, expected %s @%0d", kname(k), cyc, kname(mon_e.kind), mon_e.at);
          end
        end
      end
    end
  end
  task automatic check(input string name, input int act, input int req);
    n_run++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask
  task automatic push(input int k, input int at, input int lim);
    if (at <= lim) exp_q.push_back('{kind: k, at: at});
  endtask
  function automatic logic line_at(input int o, input int ps, input bit par, input logic [7:0] d);
    int k;
    if (o == 0) return 1'b0;
    k = (o - 1) / ps;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && par) return ^d;
    return 1'b1;
  endfunction
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) tick();
  endtask
  task automatic frame(input int ps, input bit par, input logic [7:0] d, input bit glitch,
                       input bit perr, input bit serr, input bit b2b, input int rst_at);
    int base, chk, lim, stop_k, len;
    base = cyc;
    chk = ps / 2 + 2;
    lim = rst_at > 0 ? base + rst_at : base + 100000;
    stop_k = par ? 10 : 9;
    push(0, base + 1 + chk, lim);
    if (!glitch) begin
      for (int i = 0; i < 8; i++) push(1, base + 1 + (1 + i) * ps + chk, lim);
      if (par) push(2, base + 1 + 9 * ps + chk, lim);
      push(3, base + 1 + stop_k * ps + chk, lim);
      push(serr ? 6 : (par && perr) ? 5 : 4, base + 2 + stop_k * ps + chk, lim);
    end
    len = glitch ? 12 : rst_at > 0 ? rst_at + 2 : (stop_k + 1) * ps + (b2b ? 0 : 2);
    for (int o = 0; o < len; o++) begin
      RX_IN = glitch ? (o >= 2) : (rst_at > 0 && o >= rst_at) ? 1'b1 : line_at(o, ps, par, d);
      RST = rst_at > 0 && o == rst_at;
      if (o == 0) begin
        prescale = 6'(ps);
        PAR_EN = par;
        strt_glitch = glitch;
        par_err = perr;
        stp_err = serr;
      end else if (o == 3) begin
        prescale = ps == 8 ? 6'd16 : 6'd8;
        PAR_EN = !par;
      end
      if (!glitch && (rst_at == 0 || o < rst_at)) begin
        if (o == 1) begin
          check("start_edge", edge_cnt, 0);
          check("start_samp", dat_samp_en, 1);
        end
        if (o == 1 + 2 * ps + 3) begin
          check("data1_edge", edge_cnt, 3);
          check("data1_bit", bit_cnt, 1);
        end
        if (o == 1 + 8 * ps + 2) check("data7_bit", bit_cnt, 7);
      end
      if (glitch && o == 7) check("glitch_busy", dat_samp_en, 1);
      if (glitch && o == 8) begin
        check("glitch_idle", dat_samp_en, 0);
        check("glitch_edge", edge_cnt, 0);
      end
      if (rst_at > 0 && o == rst_at + 1) begin
        check("rst_samp", dat_samp_en, 0);
        check("rst_edge", edge_cnt, 0);
        check("rst_bit", bit_cnt, 0);
        check("rst_pulses", {framing_error, parity_error, data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en}, 0);
      end
      if (!glitch && rst_at == 0 && !b2b && o == len - 1) check("end_idle", dat_samp_en, 0);
      tick();
    end
    RST = 1'b0;
    RX_IN = 1'b1;
  endtask
  initial begin
    repeat (3) tick();
    check("reset_samp", dat_samp_en, 0);
    check("reset_edge", edge_cnt, 0);
    check("reset_bit", bit_cnt, 0);
    check("reset_pulses", {framing_error, parity_error, data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en}, 0);
    RST = 1'b0;
    idle(2);
    frame(8, 0, 8'hA5, 0, 0, 0, 0, 0);
    frame(16, 1, 8'h3C, 0, 1, 0, 0, 0);
    frame(8, 1, 8'h0F, 0, 0, 0, 0, 0);
    frame(8, 0, 8'h00, 1, 0, 0, 0, 0);
    frame(32, 1, 8'hFF, 0, 1, 1, 0, 0);
    frame(8, 0, 8'hA5, 0, 0, 0, 1, 0);
    frame(8, 0, 8'h3C, 0, 0, 0, 0, 0);
    frame(8, 0, 8'h5A, 0, 0, 0, 0, 40);
    idle(4);
    frame(8, 0, 8'h5A, 0, 0, 0, 0, 0);
    idle(5);
    check("events_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame-sequencing controller for the UART receiver. It detects the start-bit falling edge and counts oversampling edges and bit positions. It pulses the enables of the start-check, deserializer, parity-check and stop-check datapath blocks at the correct sample edge. It collects their error flags and issues a single-cycle `data_valid` or error pulse per frame. It sits between the RX line input and the receiver datapath, and owns all RX timing.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; `bit_cnt` is sized to cover it.
- `CLK`  in  1  oversampling clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `RX_IN`  in  1  serial line, idle high.
- `PAR_EN`  in  1  parity bit present in frame; latched at frame start.
- `prescale`  in  6  oversampling ratio; legal values 8, 16, 32; latched at frame start.
- `strt_glitch`  in  1  start-check result (1 = start bit not low); valid in the `strt_chk_en` cycle.
- `par_err`  in  1  parity-check result; valid in the `par_chk_en` cycle.
- `stp_err`  in  1  stop-check result (1 = stop bit not high); valid in the `stp_chk_en` cycle.
- `edge_cnt`  out  5  oversample edge index within the current bit, 0..prescale-1.
- `bit_cnt`  out  4  data bit index, 0..DATA_WIDTH-1.
- `dat_samp_en`  out  1  data sampler enable; high in every non-IDLE state.
- `strt_chk_en`, `deser_en`, `par_chk_en`, `stp_chk_en`  out  1 each  one-cycle check/shift strobes.
- `data_valid`  out  1  one-cycle pulse for a frame received with no error.
- `parity_error`, `framing_error`  out  1 each  one-cycle pulses, coincident with the cycle `data_valid` would occur.

## Operation
- Reset: state IDLE. All outputs 0, both counters 0, latched error flag 0.
- Check edge: CHK = prescale/2 + 2.
  - The sampler takes its majority samples at edges prescale/2-1, prescale/2 and prescale/2+1.
  - Every strobe fires at `edge_cnt == CHK` for exactly one cycle.
- End of bit: `edge_cnt == prescale-1`. `edge_cnt` then wraps to 0.
- IDLE → START: taken when `RX_IN == 0` is registered. On the transition:
  - latch `prescale` and `PAR_EN`;
  - set `edge_cnt` to 0.
- START:
  - At CHK, `strt_chk_en` fires. If `strt_glitch` is 1, go to IDLE next cycle with no output pulse.
  - At end of bit, go to DATA with `bit_cnt` = 0.
- DATA:
  - At CHK, `deser_en` fires.
  - At end of bit, `bit_cnt` increments.
  - At end of bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN is 1, else STOP. `bit_cnt` returns to 0.
- PARITY:
  - At CHK, `par_chk_en` fires, and `par_err` is OR-ed into the latched flag.
  - At end of bit, go to STOP.
- STOP:
  - At CHK, `stp_chk_en` fires, and `stp_err` is captured.
  - On the next cycle, exactly one of the following pulses:
    - `data_valid`, if there is no error;
    - `framing_error`, if `stp_err` was 1;
    - `parity_error`, if the latched parity flag is set and `stp_err` was 0. Framing error has priority.
- STOP at end of bit: if `RX_IN == 0`, go directly to START with `edge_cnt` = 0 (back-to-back frames). Otherwise go to IDLE.
- Leaving STOP clears the latched parity flag.
- Illegal `prescale`: behaviour undefined; the bench does not drive it.
- `prescale` and `PAR_EN` changes mid-frame: ignored until the next frame start.

## Timing
- All outputs are registered. Strobes are high in the cycle where the registered `edge_cnt == CHK`.
- Cycle 0 is the cycle in which IDLE registers `RX_IN == 0`. Cycle 1 has START with `edge_cnt` = 0.
- Worked example, prescale = 8, no parity:
  - `strt_chk_en` at cycle 7;
  - DATA spans cycles 9..72, with `deser_en` at cycles 15, 23, …, 71;
  - STOP spans cycles 73..80, with `stp_chk_en` at cycle 79;
  - `data_valid` at cycle 80;
  - IDLE at cycle 81.
- With parity enabled, add prescale cycles to everything after DATA.
- Start glitch: state is IDLE in the cycle after `strt_chk_en`. The earliest new detection is one cycle later.
- Reset asserted mid-frame: IDLE on the next edge. No pulse is emitted, and the latched flag is cleared.
- Reset has priority over all transitions.

## Structure
- Package `uart_rx_pkg`:
  - state enum `IDLE`, `START`, `DATA`, `PARITY`, `STOP`;
  - localparams for the edge-counter width (5) and the bit-counter width (4).
- Sub-module `uart_edge_bit_counter`:
  - holds `edge_cnt` and `bit_cnt`, with enable, clear and latched `prescale`;
  - outputs an end-of-bit flag and a last-bit flag.
- The FSM and strobe/flag logic live in `uart_rx_ctrl`.

## Test plan
- prescale = 8, PAR_EN = 0, byte 0xA5, clean stop → `deser_en` ×8 at cycles 15..71 step 8; `data_valid` at cycle 80; no error pulse.
- prescale = 16, PAR_EN = 1, `par_err` = 1 at `par_chk_en` → `parity_error` one cycle after `stp_chk_en`; `data_valid` stays 0.
- prescale = 8, RX_IN low for 2 cycles only, `strt_glitch` = 1 → IDLE at cycle 8; no `deser_en` and no pulses.
- prescale = 32, `stp_err` = 1 together with a parity error → `framing_error` only.
- Two back-to-back frames with prescale = 8, next start bit low at cycle 81 → START at cycle 81, second `data_valid` at cycle 160.
- `RST` high at cycle 40 of a frame → all outputs 0 and IDLE at cycle 41; the next frame decodes correctly.
